alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu.sv | 60 ++++++
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter:
// FSM states, default widths and ALU select codes.
package alu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int OPW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // ALU select codes; 13..15 are unused and produce the default result.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_BEQ = 4'd9;
    localparam logic [3:0] ALU_BNE = 4'd10;
    localparam logic [3:0] ALU_BLT = 4'd11;
    localparam logic [3:0] ALU_BGE = 4'd12;

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic/shift results on f, signed overflow
// for add/sub on ovf, branch compare outcome on take_branch.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   s,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             take_branch
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   sh;
    logic             lt;
    logic             eq;

    assign sum  = a + b;
    assign diff = a - b;
    assign sh   = b[SHW-1:0];
    assign lt   = $signed(a) < $signed(b);
    assign eq   = (a == b);

    // Select the operation; unused codes leave everything at zero.
    always_comb begin
        f           = '0;
        ovf         = 1'b0;
        take_branch = 1'b0;
        case (s)
            OPW'(ALU_ADD): begin
                f   = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OPW'(ALU_SUB): begin
                f   = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OPW'(ALU_AND): f = a & b;
            OPW'(ALU_OR):  f = a | b;
            OPW'(ALU_XOR): f = a ^ b;
            OPW'(ALU_SLL): f = a << sh;
            OPW'(ALU_SRL): f = a >> sh;
            OPW'(ALU_SRA): f = $signed(a) >>> sh;
            OPW'(ALU_SLT): f = {{(WIDTH-1){1'b0}}, lt};
            OPW'(ALU_BEQ): take_branch = eq;
            OPW'(ALU_BNE): take_branch = !eq;
            OPW'(ALU_BLT): take_branch = lt;
            OPW'(ALU_BGE): take_branch = !lt;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. A request is
// accepted in IDLE, evaluated in EXEC and held as a response in RESP until
// the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [OPW-1:0]   r0_s,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [OPW-1:0]   r1_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_ovf,
    output logic             rsp_take_branch,
    output logic             busy,
    output logic [15:0]      op_count
);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   s_q, s_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_tb_q, rsp_tb_d;
    logic             rsp_id_q, rsp_id_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic [1:0]       ready_vec;
    logic             accept;
    logic             win_id;
    logic [WIDTH-1:0] alu_f;
    logic             alu_ovf;
    logic             alu_tb;

    assign req_valid = {r1_valid, r0_valid};

    // A requester wins when it is alone, or on a tie when the other one was granted last.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            assign grant[gi]     = req_valid[gi] && (!req_valid[1-gi] || (last_q != 1'(gi)));
            assign ready_vec[gi] = grant[gi] && (state_q == IDLE) && !rst;
        end
    endgenerate

    assign r0_ready = ready_vec[0];
    assign r1_ready = ready_vec[1];
    assign accept   = |ready_vec;
    assign win_id   = ready_vec[1];

    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a           (a_q),
        .b           (b_q),
        .s           (s_q),
        .f           (alu_f),
        .ovf         (alu_ovf),
        .take_branch (alu_tb)
    );

    // Next-state logic: capture on accept, register ALU result in EXEC, count on handshake.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        id_d      = id_q;
        rsp_f_d   = rsp_f_q;
        rsp_ovf_d = rsp_ovf_q;
        rsp_tb_d  = rsp_tb_q;
        rsp_id_d  = rsp_id_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = win_id ? r1_a : r0_a;
                    b_d     = win_id ? r1_b : r0_b;
                    s_d     = win_id ? r1_s : r0_s;
                    id_d    = win_id;
                    last_d  = win_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_f_d   = alu_f;
                rsp_ovf_d = alu_ovf;
                rsp_tb_d  = alu_tb;
                rsp_id_d  = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any in-flight work and favours requester 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            id_q      <= 1'b0;
            rsp_f_q   <= '0;
            rsp_ovf_q <= 1'b0;
            rsp_tb_q  <= 1'b0;
            rsp_id_q  <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            id_q      <= id_d;
            rsp_f_q   <= rsp_f_d;
            rsp_ovf_q <= rsp_ovf_d;
            rsp_tb_q  <= rsp_tb_d;
            rsp_id_q  <= rsp_id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rsp_valid       = (state_q == RESP);
    assign busy            = (state_q != IDLE);
    assign rsp_f           = rsp_f_q;
    assign rsp_ovf         = rsp_ovf_q;
    assign rsp_take_branch = rsp_tb_q;
    assign rsp_id          = rsp_id_q;
    assign op_count        = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written multi-cycle
// sequences and randomized requests against a behavioural model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [15:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [3:0]  r0_s = '0, r1_s = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_f;
    logic        rsp_ovf, rsp_take_branch;
    logic        busy;
    logic [15:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(16), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_s(r0_s),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_s(r1_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
        .rsp_ovf(rsp_ovf), .rsp_take_branch(rsp_take_branch),
        .busy(busy), .op_count(op_count)
    );

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic [15:0] f;
        logic        ovf;
        logic        tb;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference behaviour of the ALU from plain integer arithmetic.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                                  output logic [15:0] f, output logic ovf, output logic tb);
        int sa, sb, r, sh;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        sh  = int'(b % 16);
        f   = 16'h0;
        ovf = 1'b0;
        tb  = 1'b0;
        case (s)
            4'd0: begin r = sa + sb; f = 16'(r); ovf = (r > 32767) || (r < -32768); end
            4'd1: begin r = sa - sb; f = 16'(r); ovf = (r > 32767) || (r < -32768); end
            4'd2: f = a & b;
            4'd3: f = a | b;
            4'd4: f = a ^ b;
            4'd5: f = 16'(int'(a) * (1 << sh));
            4'd6: f = 16'(int'(a) / (1 << sh));
            4'd7: f = 16'(sa >>> sh);
            4'd8: f = (sa < sb) ? 16'd1 : 16'd0;
            4'd9:  tb = (a == b);
            4'd10: tb = (a != b);
            4'd11: tb = (sa < sb);
            4'd12: tb = (sa >= sb);
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom());
        endcase
    endfunction

    // One full transaction: present request(s), check grant, latency, result and count.
    task automatic do_req(input logic v0, input logic v1,
                          input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] s0,
                          input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] s1,
                          input int eid, input logic [15:0] ef, input logic eo, input logic et,
                          input int stall, input string nm);
        int t;
        @(negedge clk);
        r0_valid = v0; r0_a = a0; r0_b = b0; r0_s = s0;
        r1_valid = v1; r1_a = a1; r1_b = b1; r1_s = s1;
        rsp_ready = 1'b0;
        #1;
        t = 0;
        while (!(r0_ready || r1_ready) && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " r0_ready"}, r0_ready, eid == 0);
        chk({nm, " r1_ready"}, r1_ready, eid == 1);
        if (!(r0_ready || r1_ready)) begin
            r0_valid = 1'b0;
            r1_valid = 1'b0;
            return;
        end
        @(negedge clk);
        chk({nm, " exec_rsp_valid"}, rsp_valid, 0);
        chk({nm, " exec_busy"}, busy, 1);
        chk({nm, " exec_ready"}, r0_ready | r1_ready, 0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        chk({nm, " rsp_valid"}, rsp_valid, 1);
        chk({nm, " rsp_id"}, rsp_id, eid);
        chk({nm, " rsp_f"}, rsp_f, ef);
        chk({nm, " rsp_ovf"}, rsp_ovf, eo);
        chk({nm, " rsp_tb"}, rsp_take_branch, et);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, " hold_valid"}, rsp_valid, 1);
            chk({nm, " hold_f"}, rsp_f, ef);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_count = (exp_count + 1) & 16'hFFFF;
        chk({nm, " op_count"}, op_count, exp_count);
        chk({nm, " idle_rsp_valid"}, rsp_valid, 0);
        chk({nm, " idle_busy"}, busy, 0);
        model_last = eid;
        $display("txn %s id=%0d f=%h ovf=%0d tb=%0d count=%0d", nm, eid, rsp_f, rsp_ovf, rsp_take_branch, op_count);
    endtask

    initial begin
        int grants[8];
        int rids[8];
        logic [15:0] rfs[8];
        int ng, nr, t;
        logic [15:0] ef, ra, rb;
        logic eo, et;
        logic [3:0] rs;
        int pat, eid;

        vecs[0]  = '{0, 16'h03DB, 16'h02A6, 4'd0,  16'h0681, 1'b0, 1'b0};
        vecs[1]  = '{1, 16'hA415, 16'hA555, 4'd0,  16'h496A, 1'b1, 1'b0};
        vecs[2]  = '{0, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 1'b1, 1'b0};
        vecs[3]  = '{1, 16'h8000, 16'h0001, 4'd1,  16'h7FFF, 1'b1, 1'b0};
        vecs[4]  = '{0, 16'h00F0, 16'h0F0F, 4'd2,  16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1, 16'h00F0, 16'h0F0F, 4'd3,  16'h0FFF, 1'b0, 1'b0};
        vecs[6]  = '{0, 16'h1234, 16'h00FF, 4'd4,  16'h12CB, 1'b0, 1'b0};
        vecs[7]  = '{1, 16'h0001, 16'h0013, 4'd5,  16'h0008, 1'b0, 1'b0};
        vecs[8]  = '{0, 16'h8000, 16'h0004, 4'd6,  16'h0800, 1'b0, 1'b0};
        vecs[9]  = '{1, 16'h8000, 16'h0004, 4'd7,  16'hF800, 1'b0, 1'b0};
        vecs[10] = '{0, 16'hFFFF, 16'h0001, 4'd8,  16'h0001, 1'b0, 1'b0};
        vecs[11] = '{1, 16'h5555, 16'h5555, 4'd9,  16'h0000, 1'b0, 1'b1};
        vecs[12] = '{0, 16'h0001, 16'h0002, 4'd10, 16'h0000, 1'b0, 1'b1};
        vecs[13] = '{1, 16'hFFFE, 16'h0001, 4'd11, 16'h0000, 1'b0, 1'b1};
        vecs[14] = '{0, 16'h1234, 16'h5678, 4'd15, 16'h0000, 1'b0, 1'b0};

        // Reset: requests held high must not be granted while rst is asserted.
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        @(negedge clk);
        chk("rst r0_ready", r0_ready, 0);
        chk("rst r1_ready", r1_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_f", rsp_f, 0);
        chk("rst rsp_ovf", rsp_ovf, 0);
        chk("rst rsp_tb", rsp_take_branch, 0);
        chk("rst rsp_id", rsp_id, 0);
        chk("rst op_count", op_count, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;
        exp_count = 0;
        model_last = 1;

        // Both requesters valid continuously: grants alternate starting with r0.
        r0_a = 16'd1;  r0_b = 16'd2;  r0_s = 4'd0;
        r1_a = 16'd10; r1_b = 16'd20; r1_s = 4'd0;
        rsp_ready = 1'b1;
        #1;
        ng = 0; nr = 0; t = 0;
        while (nr < 4 && t < 40) begin
            if (r0_ready && ng < 8) begin grants[ng] = 0; ng++; end
            if (r1_ready && ng < 8) begin grants[ng] = 1; ng++; end
            if (rsp_valid && rsp_ready) begin rids[nr] = rsp_id; rfs[nr] = rsp_f; nr++; end
            @(negedge clk);
            t++;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_count = 4;
        chk("alt responses", nr, 4);
        chk("alt op_count", op_count, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("alt grant%0d", k), (k < ng) ? grants[k] : -1, k % 2);
            chk($sformatf("alt rsp_id%0d", k), (k < nr) ? rids[k] : -1, k % 2);
            chk($sformatf("alt rsp_f%0d", k), (k < nr) ? rfs[k] : 16'hDEAD, (k % 2) ? 16'd30 : 16'd3);
            $display("txn alt%0d grant=%0d id=%0d f=%h", k, grants[k], rids[k], rfs[k]);
        end
        model_last = 1;

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].id == 0, vecs[i].id == 1,
                   vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].s,
                   vecs[i].id, vecs[i].f, vecs[i].ovf, vecs[i].tb, i % 3, $sformatf("vec%0d", i));
        end

        // Response stalled five cycles while r0 inputs churn.
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 16'h1111; r0_b = 16'h2222; r0_s = 4'd0;
        rsp_ready = 1'b0;
        #1;
        t = 0;
        while (!r0_ready && t < 10) begin @(negedge clk); t++; end
        chk("stall accept", r0_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall rsp_valid", rsp_valid, 1);
            chk("stall rsp_f", rsp_f, 16'h3333);
            chk("stall rsp_id", rsp_id, 0);
            chk("stall ready", r0_ready | r1_ready, 0);
            chk("stall op_count", op_count, exp_count);
            r0_a = 16'($urandom());
            r0_b = 16'($urandom());
            r0_s = 4'($urandom());
        end
        rsp_ready = 1'b1;
        r0_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_count = (exp_count + 1) & 16'hFFFF;
        chk("stall release count", op_count, exp_count);
        chk("stall release valid", rsp_valid, 0);
        @(negedge clk);
        chk("stall single increment", op_count, exp_count);
        $display("txn stall f=3333 count=%0d", op_count);
        model_last = 0;

        // Reset during EXEC discards the operation and restores r0 tie priority.
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 16'h0005; r0_b = 16'h0003; r0_s = 4'd1;
        #1;
        t = 0;
        while (!r0_ready && t < 10) begin @(negedge clk); t++; end
        chk("rstx accept", r0_ready, 1);
        @(negedge clk);
        chk("rstx busy", busy, 1);
        rst = 1'b1;
        r1_valid = 1'b1; r1_a = 16'h0007; r1_b = 16'h0001; r1_s = 4'd0;
        @(negedge clk);
        chk("rstx ready during rst", r0_ready | r1_ready, 0);
        rst = 1'b0;
        #1;
        exp_count = 0;
        chk("rstx rsp_valid", rsp_valid, 0);
        chk("rstx op_count", op_count, 0);
        chk("rstx busy idle", busy, 0);
        chk("rstx tie r0", r0_ready, 1);
        chk("rstx tie r1", r1_ready, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        chk("rstx rsp_id", rsp_id, 0);
        chk("rstx rsp_f", rsp_f, 16'h0002);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_count = 1;
        chk("rstx count", op_count, 1);
        $display("txn rst_exec id=0 f=%h count=%0d", rsp_f, op_count);
        model_last = 0;

        // Randomized requests, including ties, against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a0, b0, a1, b1;
            logic [3:0]  s0, s1;
            pat = $urandom_range(1, 3);
            a0 = pick(); b0 = pick(); s0 = 4'($urandom_range(0, 15));
            a1 = pick(); b1 = pick(); s1 = 4'($urandom_range(0, 15));
            eid = (pat == 1) ? 0 : (pat == 2) ? 1 : ((model_last == 0) ? 1 : 0);
            ra = eid ? a1 : a0;
            rb = eid ? b1 : b0;
            rs = eid ? s1 : s0;
            model(ra, rb, rs, ef, eo, et);
            do_req(pat != 2, pat != 1, a0, b0, s0, a1, b1, s1, eid, ef, eo, et,
                   $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
